// File: rtl/mult_div_pkg.sv
// Shared state encoding and write-back select codes for the HI/LO sequencer.
package mult_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [2:0] MTR_ALU  = 3'd0;
    localparam logic [2:0] MTR_HIGH = 3'd2;
    localparam logic [2:0] MTR_LOW  = 3'd3;
    localparam int         ITER     = 32;

endpackage

// File: rtl/mult_div_ctrl_if.sv
// Handshake/bus bundle between main control, operand latches, write-back mux and the HI/LO sequencer.
// MULT_DIV_UNSIGNED_EN adds the is_unsigned request qualifier.
interface mult_div_ctrl_if #(parameter int XLEN = 32);

    logic            start_mult;
    logic            start_div;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            rd_hilo;
    logic            rd_hi;
`ifdef MULT_DIV_UNSIGNED_EN
    logic            is_unsigned;
`endif
    logic [XLEN-1:0] High;
    logic [XLEN-1:0] Low;
    logic            busy;
    logic            done;
    logic            div_zero;
    logic            stall;
    logic [2:0]      mem_to_reg_sel;

    modport master (
`ifdef MULT_DIV_UNSIGNED_EN
        output is_unsigned,
`endif
        output start_mult, start_div, A, B, rd_hilo, rd_hi,
        input  High, Low, busy, done, div_zero, stall, mem_to_reg_sel
    );

    modport slave (
`ifdef MULT_DIV_UNSIGNED_EN
        input  is_unsigned,
`endif
        input  start_mult, start_div, A, B, rd_hilo, rd_hi,
        output High, Low, busy, done, div_zero, stall, mem_to_reg_sel
    );

endinterface

// File: rtl/mult_div_step.sv
// One iteration of the unsigned shift-add multiply or restoring divide on {hi, lo}.
module mult_div_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] opnd_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            fits;

    // Divide shifts the next dividend bit into the partial remainder; when the
    // divisor fits, the true difference is below the divisor so XLEN bits suffice.
    always_comb begin
        sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
        shifted = {hi_i, lo_i[XLEN-1]};
        fits    = (shifted >= {1'b0, opnd_i});
        diff    = shifted[XLEN-1:0] - opnd_i;
        if (is_div) begin
            hi_o = fits ? diff : shifted[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], fits};
        end else begin
            hi_o = sum[XLEN:1];
            lo_o = {sum[0], lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_ctrl.sv
// HI/LO multicycle multiply/divide sequencer with mfhi/mflo stall and write-back select.
// MULT_DIV_UNSIGNED_EN enables multu/divu through the is_unsigned bus signal.
module mult_div_ctrl
    import mult_div_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = mult_div_pkg::ITER
) (
    input  logic               clk,
    input  logic               reset,
    mult_div_ctrl_if.slave     bus
);

    localparam int CW = $clog2(ITER);

    state_e          state_q, state_d;
    logic [XLEN-1:0] high_q, high_d;
    logic [XLEN-1:0] low_q, low_d;
    logic [XLEN-1:0] acc_hi_q, acc_hi_d;
    logic [XLEN-1:0] acc_lo_q, acc_lo_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic            dz_q, dz_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            signed_op;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN-1:0] step_hi, step_lo;
    logic [2*XLEN-1:0] prod;

`ifdef MULT_DIV_UNSIGNED_EN
    assign signed_op = !bus.is_unsigned;
`else
    assign signed_op = 1'b1;
`endif

    assign a_neg = signed_op && bus.A[XLEN-1];
    assign b_neg = signed_op && bus.B[XLEN-1];
    assign a_mag = a_neg ? -bus.A : bus.A;
    assign b_mag = b_neg ? -bus.B : bus.B;

    mult_div_step #(.XLEN(XLEN)) u_step (
        .is_div (state_q == DIV),
        .hi_i   (acc_hi_q),
        .lo_i   (acc_lo_q),
        .opnd_i (opnd_q),
        .hi_o   (step_hi),
        .lo_o   (step_lo)
    );

    assign prod = {step_hi, step_lo};

    // High/Low only change on the final iteration, so a read mid-operation
    // never exposes the accumulator; it stalls instead.
    always_comb begin
        state_d   = state_q;
        high_d    = high_q;
        low_d     = low_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opnd_d    = opnd_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start_mult || (bus.start_div && bus.B != '0)) begin
                    state_d   = bus.start_mult ? MULT : DIV;
                    acc_hi_d  = '0;
                    acc_lo_d  = a_mag;
                    opnd_d    = b_mag;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dz_d      = 1'b0;
                    cnt_d     = '0;
                end else if (bus.start_div) begin
                    state_d = DONE;
                    dz_d    = 1'b1;
                end
            end
            MULT, DIV: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = DONE;
                    if (state_q == MULT) begin
                        {high_d, low_d} = neg_res_q ? -prod : prod;
                    end else begin
                        low_d  = neg_res_q ? -step_lo : step_lo;
                        high_d = neg_rem_q ? -step_hi : step_hi;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                dz_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            high_q    <= '0;
            low_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            high_q    <= high_d;
            low_q     <= low_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opnd_q    <= opnd_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.High     = high_q;
    assign bus.Low      = low_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.div_zero = (state_q == DONE) && dz_q;
    assign bus.stall    = bus.rd_hilo && (state_q != IDLE) && (state_q != DONE);
    assign bus.mem_to_reg_sel = !bus.rd_hilo ? MTR_ALU : (bus.rd_hi ? MTR_HIGH : MTR_LOW);

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl: cycle-level reference model plus directed literal checks.
module tb_mult_div_ctrl;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mult_div_ctrl_if #(.XLEN(XLEN)) bus();

    mult_div_ctrl #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passed = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: cycles left until idle, committing the arithmetic result
    // when the last iteration edge is reached.
    int          mLeft = 0;
    logic [31:0] mHigh = '0, mLow = '0, pHigh = '0, pLow = '0;
    logic        mDz = 1'b0;
    longint      pa, pb, pr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mLeft = 0; mHigh = '0; mLow = '0; mDz = 1'b0;
        end else if (mLeft > 0) begin
            mLeft--;
            if (mLeft == 1 && !mDz) begin mHigh = pHigh; mLow = pLow; end
            if (mLeft == 0) mDz = 1'b0;
        end else if (bus.start_mult) begin
            pa = longint'($signed(bus.A)); pb = longint'($signed(bus.B));
            pr = pa * pb;
            pHigh = pr[63:32]; pLow = pr[31:0]; mLeft = 33; mDz = 1'b0;
        end else if (bus.start_div) begin
            if (bus.B == 32'd0) begin
                mLeft = 1; mDz = 1'b1;
            end else begin
                pa = longint'($signed(bus.A)); pb = longint'($signed(bus.B));
                pr = pa / pb; pLow = pr[31:0];
                pr = pa % pb; pHigh = pr[31:0];
                mLeft = 33; mDz = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("model_high", bus.High, mHigh);
        checkOutput("model_low", bus.Low, mLow);
        checkOutput("model_busy", bus.busy, mLeft > 0);
        checkOutput("model_done", bus.done, mLeft == 1);
        checkOutput("model_div_zero", bus.div_zero, (mLeft == 1) && mDz);
        checkOutput("model_stall", bus.stall, bus.rd_hilo && mLeft > 1);
        checkOutput("model_sel", bus.mem_to_reg_sel, !bus.rd_hilo ? 3'd0 : (bus.rd_hi ? 3'd2 : 3'd3));
    end

    task automatic applyStimulus(input logic sm, input logic sd, input logic [31:0] a, input logic [31:0] b);
        bus.start_mult = sm; bus.start_div = sd; bus.A = a; bus.B = b;
        @(posedge clk); #1;
        bus.start_mult = 1'b0; bus.start_div = 1'b0;
    endtask

    // Leaves the caller at the negedge inside the DONE cycle.
    task automatic runToDone(output int busyCycles);
        busyCycles = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin busyCycles = i; break; end
        end
        if (busyCycles < 0) checkOutput("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic runOp(input string name, input logic sm, input logic sd, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expHigh, input logic [31:0] expLow,
                         input int expCycles, input logic expDz);
        int n;
        applyStimulus(sm, sd, a, b);
        runToDone(n);
        checkOutput({name, "_cycles"}, n, expCycles);
        checkOutput({name, "_high"}, bus.High, expHigh);
        checkOutput({name, "_low"}, bus.Low, expLow);
        checkOutput({name, "_dz"}, bus.div_zero, expDz);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n;
        reset = 1'b1;
        bus.start_mult = 1'b0; bus.start_div = 1'b0;
        bus.A = '0; bus.B = '0; bus.rd_hilo = 1'b0; bus.rd_hi = 1'b0;
`ifdef MULT_DIV_UNSIGNED_EN
        bus.is_unsigned = 1'b0;
`endif
        @(negedge clk);
        checkOutput("reset_high", bus.High, 32'd0);
        checkOutput("reset_low", bus.Low, 32'd0);
        checkOutput("reset_busy", bus.busy, 1'b0);
        checkOutput("reset_done", bus.done, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;

        runOp("mult_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 32, 1'b0);
        runOp("mult_m5_m6", 1'b1, 1'b0, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h0, 32'd30, 32, 1'b0);
        runOp("mult_m1_m1", 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'd1, 32, 1'b0);
        runOp("div_m7_2", 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 32, 1'b0);
        runOp("div_100_7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 32, 1'b0);
        runOp("div_100_m7", 1'b0, 1'b1, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 32, 1'b0);
        runOp("div_47_7", 1'b0, 1'b1, 32'd47, 32'd7, 32'd5, 32'd6, 32, 1'b0);
        runOp("div_zero", 1'b0, 1'b1, 32'd47, 32'd0, 32'd5, 32'd6, 0, 1'b1);

        // mfhi raised at iteration 3, with an ignored start mid-operation and in DONE.
        applyStimulus(1'b1, 1'b0, 32'd123, 32'd456);
        repeat (3) @(posedge clk);
        #1;
        bus.rd_hilo = 1'b1; bus.rd_hi = 1'b1;
        bus.start_div = 1'b1;
        @(negedge clk);
        checkOutput("stall_mid", bus.stall, 1'b1);
        checkOutput("sel_mid", bus.mem_to_reg_sel, 3'd2);
        @(posedge clk); #1;
        bus.start_div = 1'b0;
        runToDone(n);
        checkOutput("stall_done", bus.stall, 1'b0);
        checkOutput("sel_done", bus.mem_to_reg_sel, 3'd2);
        checkOutput("stall_high", bus.High, 32'd0);
        checkOutput("stall_low", bus.Low, 32'd56088);
        bus.start_mult = 1'b1; bus.A = 32'd9; bus.B = 32'd9;
        @(posedge clk); #1;
        bus.start_mult = 1'b0;
        @(negedge clk);
        checkOutput("start_in_done_ignored", bus.busy, 1'b0);
        bus.rd_hilo = 1'b0; bus.rd_hi = 1'b0;
        @(posedge clk); #1;

        // Reset at iteration 10 aborts immediately.
        applyStimulus(1'b1, 1'b0, 32'h12345, 32'h777);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("abort_high", bus.High, 32'd0);
        checkOutput("abort_low", bus.Low, 32'd0);
        checkOutput("abort_busy", bus.busy, 1'b0);
        checkOutput("abort_done", bus.done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        runOp("mult_3_4", 1'b1, 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 32, 1'b0);

        runOp("both_starts", 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 32, 1'b0);
        @(negedge clk);
        checkOutput("both_div_dropped", bus.busy, 1'b0);
        @(posedge clk); #1;
        runOp("div_ovf", 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 32, 1'b0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
- Multicycle sequencer for the HI/LO special registers of the multicycle MIPS datapath.
- Runs 32-iteration signed multiply and divide, writes High/Low, and stalls main control on mfhi/mflo until the result is valid.
- Drives the write-back mux select codes for the High (2) and Low (3) sources.
- Sits between the main control FSM, the register-file operand latches A/B and the write-back mux.

Parameters:
- XLEN, 32, operand/result width.
- ITER, 32, iteration count; must equal XLEN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_mult  in  1  one-cycle request: High:Low <= A*B.
- start_div  in  1  one-cycle request: Low <= A/B, High <= A%B.
- A  in  XLEN  operand A (rs).
- B  in  XLEN  operand B (rt).
- rd_hilo  in  1  main control is executing mfhi/mflo.
- rd_hi  in  1  1 = mfhi, 0 = mflo (valid with rd_hilo).
- High  out  XLEN  HI register.
- Low  out  XLEN  LO register.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  one-cycle pulse with done when the divisor was 0.
- stall  out  1  main control must hold its state.
- mem_to_reg_sel  out  3  write-back mux select for mfhi/mflo.

Behaviour:
- Reset (async, immediate): state IDLE; High=0, Low=0, busy=0, done=0, div_zero=0, counter=0.
- States: IDLE, MULT, DIV, DONE.
- IDLE:
  - start_mult at edge E0: latch A, B, and signs; go to MULT.
  - start_div at E0 with B!=0: go to DIV.
  - start_div at E0 with B==0: go directly to DONE with div_zero set; High/Low unchanged.
  - Both starts high: multiply wins, start_div dropped.
- MULT/DIV:
  - One iteration per edge, E1..E32. A 5-bit counter is cleared at E0, increments each iteration and leaves at count 31.
  - Edge E32 writes High/Low and enters DONE.
- DONE: lasts one cycle with done=1 (div_zero=1 if applicable), then returns to IDLE.
  - A start in the DONE cycle is ignored.
  - Earliest back-to-back start is the cycle after DONE.
- busy=1 in MULT, DIV and DONE; 0 in IDLE. Starts while busy are ignored, with no queueing.
- Multiply:
  - Signed 32x32 -> 64-bit two's complement.
  - Unsigned shift-add on operand magnitudes, negated at E32 if signs differ.
  - High = bits 63:32, Low = bits 31:0.
- Divide:
  - Signed restoring division on magnitudes; quotient truncated toward zero.
  - Remainder takes the sign of the dividend. Low = quotient, High = remainder.
  - 0x80000000 / 0xFFFFFFFF gives Low=0x80000000, High=0 (quotient magnitude wraps, no trap).
- Write-back select, combinational:
  - mem_to_reg_sel = 3'd2 when rd_hilo&&rd_hi, 3'd3 when rd_hilo&&!rd_hi, else 3'd0.
  - stall = rd_hilo && busy && !done. In the DONE cycle High/Low are already valid, so there is no stall.
- High/Low are written only at completion. Intermediate state lives in internal accumulator/remainder registers, so mfhi during an operation never sees partial values; it stalls instead.
- Reset mid-operation aborts; no High/Low write occurs.

Optional Feature:
- Macro: MULT_DIV_UNSIGNED_EN.
- Defined: adds input is_unsigned (1 bit), sampled with the start.
  - When 1, implements multu/divu: no magnitude conversion or sign fix-up.
  - divu 0x80000000/0xFFFFFFFF gives Low=0, High=0x80000000.
- Undefined: port absent; all operations signed.

Decomposition:
- Package mult_div_pkg:
  - State enum (IDLE=0, MULT=1, DIV=2, DONE=3).
  - Constants MTR_ALU=3'd0, MTR_HIGH=3'd2, MTR_LOW=3'd3, ITER=32.
- One sub-module, mult_div_step: a combinational single-iteration datapath (shift-add step / restore-subtract step) instantiated once, with the FSM and registers in mult_div_ctrl.

Test Plan:
- mult A=7, B=0xFFFFFFFD -> busy for E0..E32, done pulse after E32, High=0xFFFFFFFF, Low=0xFFFFFFEB.
- div A=0xFFFFFFF9 (-7), B=2 -> Low=0xFFFFFFFD, High=0xFFFFFFFF; then div 100/7 -> Low=14, High=2.
- div with B=0 and High/Low preloaded to 5/6 -> done and div_zero high in the cycle after E0; High=5, Low=6.
- rd_hilo=1, rd_hi=1 raised at iteration 3 -> stall=1 until the DONE cycle, mem_to_reg_sel=3'd2 throughout, High valid when stall drops.
- Reset pulsed at iteration 10 -> all outputs 0 immediately; start_mult in the next cycle completes correctly (3*4 -> Low=12, High=0).
- start_mult and start_div together (A=0x80000000, B=0xFFFFFFFF) -> multiply runs (High=0, Low=0x80000000); a later div on the same operands -> Low=0x80000000, High=0.
